ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data/address width; only 32 is supported.
REQ-002 Parameter: RAM_SIZE, 'h600, RAM depth in 32-bit words.
REQ-003 Port: CLK, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: RESET, input, 1, synchronous active-high reset.
REQ-005 Ports: i_valid in 1, i_addr in XLEN, i_ready out 1; instruction-fetch read request.
REQ-006 Ports: i_rvalid out 1, i_rdata out XLEN, i_err out 1; instruction-fetch response.
REQ-007 Ports: d_valid in 1, d_addr in XLEN, d_we in 1, d_wdata in XLEN, d_wmask in 4; data request.
REQ-008 Ports: d_ready out 1, d_rvalid out 1, d_rdata out XLEN, d_err out 1; data handshake and response.
REQ-009 Ports: ram_en out 1, ram_we out 1, ram_addr out clog2(RAM_SIZE), ram_wdata out XLEN, ram_wmask out 4, ram_rdata in XLEN; single-port RAM with 1-cycle read latency.

Function
REQ-010 Request accepted when valid and ready are both high in the same cycle; at most one port is granted per cycle.
REQ-011 Requester holds valid, addr, we, wdata, wmask stable until accepted; the arbiter does not latch a request before acceptance.
REQ-012 ready is combinational from valid and arbitration state; granted port's ready=1, other port's ready=0.
REQ-013 On acceptance with in-range address, ram_en=1 same cycle, ram_addr=addr[2+:clog2(RAM_SIZE)], ram_we=d_we for data port and 0 for fetch port.
REQ-014 In range: addr[31:2] < RAM_SIZE. addr[1:0] ignored; masks are byte-lane enables, not realigned.
REQ-015 Out-of-range accept: ram_en=0, no RAM access; response carries err=1 and rdata=0.
REQ-016 Response exactly one cycle after acceptance: owner's rvalid=1 for one cycle; rdata=ram_rdata for in-range reads; writes also produce rvalid (ack) with rdata=0.
REQ-017 Response routing uses a registered owner field with states NONE, IBUS, DBUS; next value = granted port, or NONE when no acceptance.
REQ-018 Fully pipelined: a new request may be accepted in the same cycle as the previous response; sustained throughput one access per cycle.
REQ-019 Non-owner's rvalid and err are 0; non-owner's rdata is 0.
REQ-020 Only one valid: that port is granted regardless of priority state.

Reset
REQ-021 RESET high at a clock edge: owner=NONE, last_grant=IBUS; all rvalid/err=0, all rdata=0.
REQ-022 During RESET: i_ready=d_ready=0, ram_en=0; a response pending at reset is dropped, never delivered.
REQ-023 First cycle after RESET deasserts: requests are accepted normally.

Configuration
REQ-024 Macro RAM_ARB_ROUND_ROBIN_EN defined: both valid -> grant the port not recorded in last_grant; last_grant updates on every acceptance.
REQ-025 Macro undefined: fixed priority, data port always wins; last_grant register absent; fetch starves while d_valid is held high.

Verification
REQ-026 RAM word 4 = 32'hDEADBEEF; i_valid, i_addr=0x10 alone -> i_ready same cycle, ram_addr=4; next cycle i_rvalid=1, i_rdata=32'hDEADBEEF, d_rvalid=0.
REQ-027 d_we=1, d_addr=0x20, d_wdata=32'h12345678, d_wmask=4'b0011 -> ram_we=1, ram_addr=8, ram_wmask=4'b0011; next cycle d_rvalid=1, d_err=0, d_rdata=0.
REQ-028 i_addr=0x1800 (word 'h600) -> i_ready=1, ram_en=0; next cycle i_rvalid=1, i_err=1, i_rdata=0.
REQ-029 Both valid for 4 cycles after reset -> grant order D,I,D,I with RAM_ARB_ROUND_ROBIN_EN; D,D,D,D without.
REQ-030 Back-to-back reads of words 1,2,3 on data port -> d_rvalid high 3 consecutive cycles with matching data, no bubbles.
REQ-031 Read accepted, RESET high next edge -> no rvalid pulse on either port; owner=NONE.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port RAM; RAM_ARB_ROUND_ROBIN_EN selects round-robin, else data wins.
// Latency: accept in cycle N, response in N+1; throughput 1/cycle; loser sees ready=0 and must hold its request.
module ram_arbiter #(
  parameter int XLEN     = 32,
  parameter int RAM_SIZE = 'h600,
  localparam int AW      = $clog2(RAM_SIZE)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ready,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_err,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_addr,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wmask,
  output logic            d_ready,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  output logic [3:0]      ram_wmask,
  input  logic [XLEN-1:0] ram_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IBUS = 2'd1;
  localparam logic [1:0] OWN_DBUS = 2'd2;

  localparam logic [XLEN-1:0] RAM_WORDS = XLEN'(RAM_SIZE);

  logic       grant_i, grant_d, prio_d;
  logic       i_in_range, d_in_range, sel_in_range;
  logic [1:0] owner;
  logic       resp_err, resp_rd;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // byte offset bits are ignored; range is checked on the word index
  assign i_in_range = {2'b00, i_addr[XLEN-1:2]} < RAM_WORDS;
  assign d_in_range = {2'b00, d_addr[XLEN-1:2]} < RAM_WORDS;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_grant_dbus;

  assign prio_d = !last_grant_dbus;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant_dbus <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_grant_dbus <= grant_d;
    end
  end
`else
  assign prio_d = 1'b1;
`endif

  assign grant_d = !RESET && d_valid && (!i_valid || prio_d);
  assign grant_i = !RESET && i_valid && !grant_d;
  assign i_ready = grant_i;
  assign d_ready = grant_d;

  assign sel_in_range = grant_d ? d_in_range : i_in_range;

  assign ram_en    = (grant_d && d_in_range) || (grant_i && i_in_range);
  assign ram_we    = grant_d && d_in_range && d_we;
  assign ram_addr  = grant_d ? d_addr[2 +: AW] : i_addr[2 +: AW];
  assign ram_wdata = d_wdata;
  assign ram_wmask = grant_d ? d_wmask : 4'b0000;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner    <= OWN_NONE;
      resp_err <= 1'b0;
      resp_rd  <= 1'b0;
    end else begin
      owner    <= grant_d ? OWN_DBUS : (grant_i ? OWN_IBUS : OWN_NONE);
      resp_err <= (grant_i || grant_d) && !sel_in_range;
      resp_rd  <= (grant_i || grant_d) && sel_in_range && !(grant_d && d_we);
    end
  end

  // responses are masked while RESET is high so a pending one is dropped
  always_comb begin
    i_rvalid = 1'b0;
    i_err    = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_err    = 1'b0;
    d_rdata  = '0;
    if (!RESET) begin
      if (owner == OWN_IBUS) begin
        i_rvalid = 1'b1;
        i_err    = resp_err;
        i_rdata  = resp_rd ? ram_rdata : '0;
      end else if (owner == OWN_DBUS) begin
        d_rvalid = 1'b1;
        d_err    = resp_err;
        d_rdata  = resp_rd ? ram_rdata : '0;
      end
    end
  end

endmodule
